// File: rtl/fp_round_pack_stage.sv
// fp_round_pack_stage: two-stage round-to-nearest-even and IEEE-754 single pack with valid/ready.
// Optional macro ROUND_MODE_EN adds rnd_mode (RNE/RTZ/RUP/RDN) with directed-rounding overflow saturation.
module fp_round_pack_stage #(
  parameter int EXP_W = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [FRAC_W+3:0]       in_sig,
  input  logic                    in_zero,
`ifdef ROUND_MODE_EN
  input  logic [1:0]              rnd_mode,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_data,
  output logic [2:0]              out_flags
);
  logic adv, l, g, r, s, any, inc;
  logic v1, sign1, inc1, inx1, zero1, carry, c;
  logic [EXP_W-1:0] exp1;
  logic [FRAC_W:0] sig1;
  logic [FRAC_W-1:0] f;
  logic [EXP_W:0] exp_f;
  logic [EXP_W+FRAC_W:0] zero_word, ovf_word, pack;
  logic [2:0] flg;
  assign adv = !out_valid | out_ready;
  assign in_ready = adv;
  assign {l, g, r, s} = in_sig[3:0];
  assign any = g | r | s;
`ifdef ROUND_MODE_EN
  logic [1:0] mode1;
  logic sat;
  assign inc = rnd_mode == 2'b00 ? g & (l | r | s) :
               rnd_mode == 2'b01 ? 1'b0 :
               rnd_mode == 2'b10 ? !in_sign & any : in_sign & any;
  assign sat = mode1 == 2'b01 | (mode1 == 2'b10 & sign1) | (mode1 == 2'b11 & !sign1);
  assign ovf_word = sat ? {sign1, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}}
                        : {sign1, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
  always_ff @(posedge clk)
    if (adv) mode1 <= rnd_mode;
`else
  assign inc = g & (l | r | s);
  assign ovf_word = {sign1, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
`endif
  always_ff @(posedge clk) begin
    if (rst) v1 <= 1'b0;
    else if (adv) v1 <= in_valid;
    if (adv) begin
      sign1 <= in_sign;
      exp1  <= in_exp;
      sig1  <= in_sig[FRAC_W+3:3];
      inc1  <= inc;
      inx1  <= any;
      zero1 <= in_zero;
    end
  end
  // Carry out of the fraction only renormalizes when the hidden bit is set; frac then wraps to 0.
  assign {c, f} = {1'b0, sig1[FRAC_W-1:0]} + {{FRAC_W{1'b0}}, inc1};
  assign carry = c & sig1[FRAC_W];
  assign exp_f = {1'b0, exp1} + {{EXP_W{1'b0}}, carry};
  assign zero_word = {sign1, {(EXP_W+FRAC_W){1'b0}}};
  always_comb begin
    pack = zero1 ? zero_word :
           exp1 == '0 ? zero_word :
           exp_f >= {1'b0, {EXP_W{1'b1}}} ? ovf_word : {sign1, exp_f[EXP_W-1:0], f};
    flg = zero1 ? 3'b000 :
          exp1 == '0 ? 3'b011 :
          exp_f >= {1'b0, {EXP_W{1'b1}}} ? 3'b101 : {2'b00, inx1};
  end
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (adv) begin
      out_valid <= v1;
      out_data  <= pack;
      out_flags <= flg;
    end
endmodule

// File: tb/tb_fp_round_pack_stage.sv
// tb_fp_round_pack_stage: directed + random scoreboard bench for the round/pack pipeline.
module tb_fp_round_pack_stage;
  logic clk = 0, rst = 1, in_valid = 0, in_sign = 0, in_zero = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [7:0] in_exp = 0;
  logic [26:0] in_sig = 0;
  logic [31:0] out_data;
  logic [2:0] out_flags;
  logic [34:0] sb[$];
  logic [34:0] exp_cur, w0;
  logic acc;
  int n_vec = 0, n_err = 0;

  fp_round_pack_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_sig(in_sig), .in_zero(in_zero), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [34:0] model(input logic sg, input logic [7:0] e, input logic [26:0] sig, input logic z);
    int unsigned m;
    int ex;
    logic [2:0] rem;
    if (z) return {sg, 31'b0, 3'b000};
    if (e == 0) return {sg, 31'b0, 3'b011};
    m = sig[26:3];
    rem = sig[2:0];
    if (rem > 4 || (rem == 4 && m[0])) m++;
    ex = e;
    if (m >= 32'h1000000) begin
      m = m >> 1;
      ex++;
    end
    if (ex >= 255) return {sg, 8'hFF, 23'b0, 3'b101};
    return {sg, ex[7:0], m[22:0], 2'b00, rem != 0};
  endfunction

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cycle();
    #1;
    acc = in_valid && in_ready === 1'b1 && !rst;
    if (!rst && out_valid === 1'b1 && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL unexpected_out: got %h expected none", {out_data, out_flags});
      end else chk("out", {out_data, out_flags}, sb.pop_front());
    end
    if (acc) sb.push_back(exp_cur);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic sg, input logic [7:0] e, input logic [26:0] sig, input logic z, input logic [34:0] expv);
    in_valid = 1;
    in_sign = sg;
    in_exp = e;
    in_sig = sig;
    in_zero = z;
    exp_cur = expv;
  endtask

  task automatic drive_rand();
    logic sg;
    logic [7:0] e;
    logic [26:0] sig;
    sg = 1'($urandom);
    e = 8'($urandom_range(1, 254));
    sig = {1'b1, 26'($urandom)};
    drive(sg, e, sig, 1'b0, model(sg, e, sig, 1'b0));
  endtask

  task automatic wait_acc();
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!acc && k < 20);
    if (!acc) chk("accept_timeout", 35'(acc), 35'd1);
    in_valid = 0;
  endtask

  task automatic drain();
    in_valid = 0;
    out_ready = 1;
    for (int k = 0; k < 20 && sb.size() > 0; k++) cycle();
    chk("drain_empty", 35'(sb.size()), 35'd0);
    repeat (3) cycle();
  endtask

  initial begin
    repeat (2) cycle();
    rst = 0;
    #1;
    chk("rst_valid", 35'(out_valid), 35'd0);
    chk("rst_data", 35'(out_data), 35'd0);
    chk("rst_flags", 35'(out_flags), 35'd0);
    chk("rst_ready", 35'(in_ready), 35'd1);
    // latency: accepted at one edge, visible after the next
    drive(0, 8'h7F, 27'h4000000, 0, {32'h3F800000, 3'b000});
    cycle();
    chk("lat_accept", 35'(acc), 35'd1);
    in_valid = 0;
    #1 chk("lat_n", 35'(out_valid), 35'd0);
    cycle();
    #1 chk("lat_n1", 35'(out_valid), 35'd1);
    drain();
    // directed rounding / special-case vectors
    drive(0, 8'h7F, 27'h4000004, 0, {32'h3F800000, 3'b001}); wait_acc();
    drive(0, 8'h7F, 27'h400000C, 0, {32'h3F800002, 3'b001}); wait_acc();
    drive(0, 8'h7F, 27'h7FFFFFF, 0, {32'h40000000, 3'b001}); wait_acc();
    drive(0, 8'hFE, 27'h7FFFFFC, 0, {32'h7F800000, 3'b101}); wait_acc();
    drive(1, 8'h55, 27'h5A5A5A5, 1, {32'h80000000, 3'b000}); wait_acc();
    drive(0, 8'h00, 27'h4000001, 0, {32'h00000000, 3'b011}); wait_acc();
    drive(1, 8'hFF, 27'h4000000, 0, {32'hFF800000, 3'b101}); wait_acc();
    drive(0, 8'hFE, 27'h4000000, 0, {32'h7F000000, 3'b000}); wait_acc();
    drive(1, 8'h80, 27'h4000006, 0, {32'hC0000001, 3'b001}); wait_acc();
    drain();
    // backpressure: 5 stalled cycles while streaming 4 words
    out_ready = 0;
    drive_rand(); w0 = exp_cur;
    cycle(); chk("bp_acc0", 35'(acc), 35'd1);
    drive_rand();
    cycle(); chk("bp_acc1", 35'(acc), 35'd1);
    drive_rand();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready_low", 35'(in_ready), 35'd0);
      chk("bp_stable", {out_data, out_flags}, w0);
      cycle();
      chk("bp_no_acc", 35'(acc), 35'd0);
    end
    out_ready = 1;
    wait_acc();
    drive_rand(); wait_acc();
    drain();
    // back-to-back throughput
    for (int i = 0; i < 8; i++) begin
      drive_rand();
      if (i >= 2) #1 chk("b2b_valid", 35'(out_valid), 35'd1);
      cycle();
      chk("b2b_acc", 35'(acc), 35'd1);
    end
    drain();
    // reset with two words in flight
    out_ready = 0;
    drive_rand(); cycle();
    drive_rand(); cycle();
    in_valid = 0;
    rst = 1;
    cycle();
    sb.delete();
    rst = 0;
    #1 chk("rst_mid_valid", 35'(out_valid), 35'd0);
    out_ready = 1;
    drive(0, 8'h90, 27'h4000010, 0, {32'h48000002, 3'b000}); wait_acc();
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fp_round_pack_stage.md
Name: fp_round_pack_stage

Overview:
- Consumer end of the extended-significand pipeline registers in the floating-point datapath.
- Accepts a 27-bit extended significand (hidden bit, fraction, guard/round/sticky), an unrounded biased exponent and a sign.
- Rounds the significand, renormalizes on carry-out and packs an IEEE-754 single-precision word.
- Two-stage pipeline with a valid/ready handshake on both sides, so the block can sit between the arithmetic core and a stalling result sink.

Parameters:
- EXP_W, 8, exponent width; only 8 is supported.
- FRAC_W, 23, fraction width; significand input width is FRAC_W+4 = 27.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts the input this cycle.
- in_sign  input  1  result sign.
- in_exp  input  8  biased exponent, before rounding.
- in_sig  input  27  [26] hidden bit, [25:3] fraction, [2] guard, [1] round, [0] sticky.
- in_zero  input  1  result is exactly zero.
- out_valid  output  1  packed result present.
- out_ready  input  1  sink accepts the result.
- out_data  output  32  {sign, exp[7:0], frac[22:0]}.
- out_flags  output  3  {overflow, underflow, inexact}.

Behaviour:
- Reset (rst=1 at an edge): internal stage valids, out_valid, out_data and out_flags all clear to 0. Reset mid-operation discards in-flight words. in_ready is 1 in the cycle after reset.
- Transfers: an input transfer happens when in_valid&in_ready; an output transfer happens when out_valid&out_ready.
- Advance: adv = !out_valid | out_ready. in_ready = adv (combinational from out_ready).
  - When adv=1: stage 2 loads stage 1, and stage 1 loads the input with valid=in_valid.
  - When adv=0: both stages hold their contents; out_data and out_flags stay stable.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N+1. Throughput is 1 word per cycle with no bubbles while out_ready=1.
- Stage 1 (rounding decision), round-to-nearest-even:
  - L=sig[3], G=sig[2], R=sig[1], S=sig[0].
  - inc = G & (L|R|S).
  - inexact = G|R|S.
  - The block registers sig[26:3], inc, inexact, sign, exp and the zero flag.
- Stage 2 (apply and pack):
  - sum[24:0] = {1'b0, sig[26:3]} + inc.
  - If sum[24]=1: frac=0 and exp=exp+1. Otherwise frac=sum[22:0].
- Special cases, checked in this priority order:
  1. in_zero → out_data = {sign, 31'b0}, flags = 0.
  2. in_exp == 0 and not zero (denormal, unsupported) → flush to {sign, 31'b0}, flags = {0, 1, 1}.
  3. Final exp ≥ 255 (including input exp=255) → out_data = {sign, 8'hFF, 23'b0}, flags = {1, 0, 1}.
  4. Otherwise → normal packing; flags = {0, 0, inexact}.
- Exponent arithmetic is 9 bits wide internally, so exp=254 plus carry is detected as 255 and never wraps.
- in_sig[26]=0 with a nonzero exponent is outside the contract; the output is unspecified but must not corrupt the handshake.
- Simultaneous events:
  - out_ready=1 and in_valid=1 while full → one word leaves and one enters in the same cycle.
  - rst overrides all handshake activity.

Optional Feature:
- Macro ROUND_MODE_EN.
- When defined: add port rnd_mode input 2, sampled together with the input word and carried through stage 1.
  - 00 RNE (as above).
  - 01 RTZ: inc = 0.
  - 10 RUP: inc = !sign & (G|R|S).
  - 11 RDN: inc = sign & (G|R|S).
  - Overflow saturates to the max finite value {sign, 8'hFE, 23'h7FFFFF} when rounding toward zero relative to the sign (RTZ; RUP with negative sign; RDN with positive sign). Otherwise overflow produces infinity.
- When not defined: no rnd_mode port; RNE is fixed; the logic is identical to mode 00.

Test Plan:
- Exact value: sign=0, exp=0x7F, sig=27'h4000000 → out_data=0x3F800000, flags=000, out_valid 2 cycles after acceptance.
- Tie to even: sig=27'h4000004 → 0x3F800000, flags=001. sig=27'h400000C → 0x3F800002, flags=001.
- Carry renormalization: exp=0x7F, sig=27'h7FFFFFF → 0x40000000, flags=001.
- Overflow: exp=0xFE, sig=27'h7FFFFFC → 0x7F800000, flags=101. in_zero=1 with sign=1 → 0x80000000, flags=000. exp=0 with sig≠0 → flags=011.
- Backpressure: stream 4 words while out_ready=0 for 5 cycles.
  - in_ready drops once 2 words are held.
  - out_data stays stable while stalled.
  - After out_ready=1, all 4 words emerge in order with none lost or duplicated.
  - With the sink always ready, back-to-back words come out 1 per cycle.
- Reset mid-stream with 2 words in flight → out_valid=0 next cycle; the next accepted word is the first one output.
